// File: rtl/inst_queue.sv
// Instruction queue: circular buffer of {inst, pc} between fetch and decode.
// Latency: a write becomes visible at the head one edge after it is accepted (no bypass).
// Backpressure: buf_avail drops when full unless a pop in the same cycle frees a slot; refused writes set sticky ovf.
module inst_queue #(
  parameter int INST_L = 32,
  parameter int PC_L   = 32,
  parameter int DEPTH  = 4   // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     buf_we,
  input  logic [INST_L-1:0]        inst_in,
  input  logic [PC_L-1:0]          pc_in,
  output logic                     buf_avail,
  output logic                     buf_ack,
  input  logic                     rd_re,
  output logic                     rd_valid,
  output logic [INST_L-1:0]        inst_out,
  output logic [PC_L-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INST_L + PC_L;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic [EW-1:0] head;

  assign empty     = (count == '0);
  // A pop in the same cycle frees the slot the write will land in, so a full queue still accepts.
  assign buf_avail = (count < FULL) || (rd_re && !empty);
  assign wr_en     = buf_we && !flush && buf_avail;
  assign rd_en     = rd_re && !flush && !empty;

  assign head      = mem[rd_ptr];
  assign rd_valid  = !empty;
  assign inst_out  = empty ? '0 : head[EW-1:PC_L];
  assign pc_out    = empty ? '0 : head[PC_L-1:0];

  // Pointer, occupancy, ack and overflow state; flush wins over any same-edge write or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      buf_ack <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      buf_ack <= wr_en;
      if (buf_we && !flush && !buf_avail)
        ovf <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
        if (rd_en)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(wr_en) - CW'(rd_en);
      end
    end
  end

  // Entry storage; only accepted writes touch it, and a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[wr_ptr] <= {inst_in, pc_in};
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter INST_L, default 32, instruction word width.
REQ-002 SHALL have parameter PC_L, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  in  1  discard all entries (branch/jump redirect).
REQ-007 SHALL have port buf_we  in  1  fetch-side write request, sampled on clk.
REQ-008 SHALL have port inst_in  in  INST_L  fetched instruction.
REQ-009 SHALL have port pc_in  in  PC_L  PC of inst_in.
REQ-010 SHALL have port buf_avail  out  1  queue can accept a write this cycle.
REQ-011 SHALL have port buf_ack  out  1  one-cycle pulse confirming an accepted write.
REQ-012 SHALL have port rd_re  in  1  decode-side pop request.
REQ-013 SHALL have port rd_valid  out  1  head entry valid (queue not empty).
REQ-014 SHALL have port inst_out  out  INST_L  head instruction.
REQ-015 SHALL have port pc_out  out  PC_L  head PC.
REQ-016 SHALL have port count  out  clog2(DEPTH)+1  occupied entries.
REQ-017 SHALL have port ovf  out  1  sticky flag: write attempted while full and not accepted.

Function
REQ-018 SHALL store entries as {inst, pc} in a circular buffer with read/write pointers of clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-019 SHALL drive buf_avail = (count < DEPTH) OR rd_re with count != 0, combinationally.
REQ-020 SHALL accept a write at an edge iff buf_we=1, flush=0, and buf_avail=1.
REQ-021 SHALL pop at an edge iff rd_re=1, flush=0, and count != 0; rd_re with count=0 is ignored.
REQ-022 SHALL, on simultaneous accepted write and pop, keep count unchanged and advance both pointers; this holds when full.
REQ-023 SHALL NOT bypass: a write into an empty queue becomes visible on rd_valid after the same edge, never in the same cycle.
REQ-024 SHALL drive rd_valid = (count != 0), with inst_out/pc_out = entry at read pointer; outputs are 0 when empty.
REQ-025 SHALL assert buf_ack for exactly the one cycle after each accepted write; a write held over N accepting cycles yields N entries and N acks.
REQ-026 SHALL, on flush=1 at an edge, set count=0 and both pointers to 0, and drop any same-edge write (no buf_ack) and any same-edge pop; flush has priority.
REQ-027 SHALL set ovf at an edge where buf_we=1, flush=0, and the write is refused; ovf clears only on rst.
REQ-028 SHALL keep count in range 0..DEPTH; update count = count + wr - rd.
REQ-029 SHALL leave stored entries unchanged except by accepted writes.

Reset
REQ-030 SHALL, while rst=1, immediately force count=0, pointers=0, rd_valid=0, buf_ack=0, ovf=0, inst_out=0, pc_out=0, buf_avail=1.
REQ-031 SHALL, on rst asserted mid-operation, discard all entries and any in-flight write without buf_ack.
REQ-032 SHALL, on the first edge after rst deasserts, accept a write normally.

Verification
REQ-033 SHALL cover fill/drain: write inst 0x11..0x44 with pc 0x0,0x4,0x8,0xC and no pops -> count=4, buf_avail=0; pop 4 times -> same order, rd_valid=0 after.
REQ-034 SHALL cover full with same-cycle write and pop: count=4, buf_we=1, rd_re=1 -> head 0x11 popped, 0x55 enqueued, count stays 4, buf_ack=1, ovf=0.
REQ-035 SHALL cover overflow: count=4, buf_we=1, rd_re=0 -> no write, buf_ack=0, ovf=1 and held until rst.
REQ-036 SHALL cover flush: count=3, flush=1 with buf_we=1 and rd_re=1 -> count=0, rd_valid=0, no buf_ack; next write of pc 0x1000 appears at head.
REQ-037 SHALL cover wrap-around: 10 write/pop pairs with DEPTH=4 -> FIFO order preserved across pointer wrap; count never exceeds 1.
REQ-038 SHALL cover async reset: rst pulsed between edges with count=2 -> outputs go to reset values before the next clk edge.
